// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the CPU request port, the video read port and the
//               single-port RAM port that meet at mem_arbiter.
//               master : requesters and RAM side (drives requests, mem_rdata)
//               slave  : the arbiter (drives acks, rdata, mem_addr/wdata/we)
//               CPU    : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ack
//               Video  : vid_req, vid_addr -> vid_rdata, vid_ack
//               RAM    : mem_addr, mem_wdata, mem_we -> mem_rdata
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vid_req, vid_addr,
        input  vid_rdata, vid_ack,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vid_req, vid_addr,
        output vid_rdata, vid_ack,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous-read RAM between the CPU
//               (read/write) and the video engine (read only). One RAM
//               transaction per grant, four cycles per access:
//               IDLE (grant) -> ACCESS -> CAPTURE -> ACK -> IDLE.
//               Ports: clk, reset (synchronous, active-high),
//                      bus (mem_arbiter_if.slave: CPU, video and RAM ports).
//               CPU_PRIORITY = 0 round-robin on ties, 1 CPU always wins ties.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CPU_PRIORITY = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    localparam logic c_OWNER_CPU = 1'b0;
    localparam logic c_OWNER_VID = 1'b1;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_owner;
    logic              r_last_owner;
    logic              r_owner_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_vid_rdata;
    logic              r_vid_ack;

    logic              w_any_req;
    logic              w_grant_cpu;

    // CPU takes the grant when it is the only requester, or on a tie when
    // priority mode is on or the video engine owned the previous access.
    always_comb begin
        w_any_req   = bus.cpu_req | bus.vid_req;
        w_grant_cpu = bus.cpu_req &
                      (~bus.vid_req | (CPU_PRIORITY != 0) | (r_last_owner == c_OWNER_VID));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_state_next = S_ACCESS;
            S_ACCESS:  w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_ACK;
            S_ACK:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= c_OWNER_VID;
            r_last_owner <= c_OWNER_VID;
            r_owner_we   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_vid_rdata  <= '0;
            r_vid_ack    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Address, data and direction are frozen here; later
                        // request-side changes cannot disturb this access.
                        r_owner    <= w_grant_cpu ? c_OWNER_CPU : c_OWNER_VID;
                        r_owner_we <= w_grant_cpu & bus.cpu_we;
                        r_mem_addr <= w_grant_cpu ? bus.cpu_addr : bus.vid_addr;
                        r_mem_we   <= w_grant_cpu & bus.cpu_we;
                        if (w_grant_cpu) begin
                            r_mem_wdata <= bus.cpu_wdata;
                        end
                    end else begin
                        r_mem_we <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    // RAM has sampled address/we at this edge: single-cycle write strobe.
                    r_mem_we <= 1'b0;
                end
                S_CAPTURE: begin
                    // mem_rdata now holds the word addressed one cycle earlier.
                    if (r_owner == c_OWNER_CPU) begin
                        if (!r_owner_we) begin
                            r_cpu_rdata <= bus.mem_rdata;
                        end
                        r_cpu_ack <= 1'b1;
                    end else begin
                        r_vid_rdata <= bus.mem_rdata;
                        r_vid_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_cpu_ack    <= 1'b0;
                    r_vid_ack    <= 1'b0;
                    r_last_owner <= r_owner;
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.vid_rdata = r_vid_rdata;
    assign bus.vid_ack   = r_vid_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. bus0/dut0 runs in
//               round-robin mode against a read/write RAM model; bus1/dut1
//               runs in CPU-priority mode against a read-only pattern RAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam bit OWN_CPU = 1'b0;
    localparam bit OWN_VID = 1'b1;

    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_PRIORITY(0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_PRIORITY(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    // Unwritten RAM locations read back a fixed address-derived pattern.
    function automatic logic [15:0] pat(input logic [15:0] a);
        pat = a ^ 16'hA5C3;
    endfunction

    // RAM behind dut0: write on the edge where mem_we is seen, data for an
    // address appears on mem_rdata one cycle after the address.
    logic [15:0] ram0  [0:65535];
    bit          wr0   [0:65535];
    always @(posedge clk) begin
        if (bus0.mem_we) begin
            ram0[bus0.mem_addr] <= bus0.mem_wdata;
            wr0[bus0.mem_addr]  <= 1'b1;
        end
        bus0.mem_rdata <= wr0[bus0.mem_addr] ? ram0[bus0.mem_addr] : pat(bus0.mem_addr);
    end

    always @(posedge clk) begin
        bus1.mem_rdata <= pat(bus1.mem_addr);
    end

    // Reference memory contents as seen through completed CPU writes.
    logic [15:0] model_mem [int];

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        model_rd = model_mem.exists(int'(a)) ? model_mem[int'(a)] : pat(a);
    endfunction

    // One CPU access on bus0 from IDLE; checks strobe, latency and read data.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              input string name);
        int lat;
        int we_cycles;
        bit seen;
        lat = 0; we_cycles = 0; seen = 0;
        bus0.cpu_req = 1'b1; bus0.cpu_we = we; bus0.cpu_addr = addr; bus0.cpu_wdata = wdata;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus0.mem_we === 1'b1) begin
                we_cycles++;
                checks++;
                if (bus0.mem_addr !== addr || bus0.mem_wdata !== wdata) begin
                    errors++;
                    $display("FAIL %s_mem_bus: addr=%h wdata=%h expected addr=%h wdata=%h",
                             name, bus0.mem_addr, bus0.mem_wdata, addr, wdata);
                end
            end
            checks++;
            if (bus0.vid_ack !== 1'b0) begin
                errors++;
                $display("FAIL %s_vid_ack: vid_ack=%b expected 0", name, bus0.vid_ack);
            end
            if (bus0.cpu_ack === 1'b1) begin
                seen = 1'b1;
                if (!we) begin
                    checks++;
                    if (bus0.cpu_rdata !== model_rd(addr)) begin
                        errors++;
                        $display("FAIL %s_rdata: cpu_rdata=%h expected %h",
                                 name, bus0.cpu_rdata, model_rd(addr));
                    end
                end
            end
        end
        bus0.cpu_req = 1'b0;
        if (we) model_mem[int'(addr)] = wdata;
        checks++;
        if (!seen || lat != 3) begin
            errors++;
            $display("FAIL %s_latency: ack_seen=%0d latency=%0d expected ack after 3 edges",
                     name, seen, lat);
        end
        checks++;
        if (we_cycles != int'(we)) begin
            errors++;
            $display("FAIL %s_we_pulse: mem_we cycles=%0d expected %0d", name, we_cycles, we);
        end
        @(negedge clk);
        checks++;
        if (bus0.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_width: cpu_ack=%b expected 0 one cycle later", name, bus0.cpu_ack);
        end
    endtask

    task automatic test_reset();
        reset0 = 1'b1; reset1 = 1'b1;
        bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
        bus0.vid_req = 0; bus0.vid_addr = 0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.vid_req = 0; bus1.vid_addr = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.cpu_ack, bus0.vid_ack, bus0.mem_we, bus0.cpu_rdata, bus0.vid_rdata,
             bus0.mem_addr, bus0.mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs0: ack=%b%b we=%b crd=%h vrd=%h addr=%h wd=%h expected all 0",
                     bus0.cpu_ack, bus0.vid_ack, bus0.mem_we, bus0.cpu_rdata, bus0.vid_rdata,
                     bus0.mem_addr, bus0.mem_wdata);
        end
        checks++;
        if ({bus1.cpu_ack, bus1.vid_ack, bus1.mem_we, bus1.cpu_rdata, bus1.vid_rdata,
             bus1.mem_addr, bus1.mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs1: nonzero output after reset, expected all 0");
        end
        reset0 = 1'b0; reset1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.mem_we !== 1'b0 || bus0.cpu_ack !== 1'b0 || bus0.vid_ack !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: we=%b cpu_ack=%b vid_ack=%b expected 0",
                         i, bus0.mem_we, bus0.cpu_ack, bus0.vid_ack);
            end
        end
    endtask

    task automatic test_cpu_write();
        cpu_access(1'b1, 16'h2000, 16'hBEEF, "cpu_write");
    endtask

    task automatic test_cpu_read();
        cpu_access(1'b0, 16'h2000, 16'h0000, "cpu_read");
    endtask

    task automatic test_random_cpu();
        for (int i = 0; i < 8; i++) begin
            cpu_access(1'($urandom_range(0, 1)), 16'h2100 + 16'($urandom_range(0, 3)),
                       16'($urandom), "cpu_random");
        end
    endtask

    // Both requesters held high: owners must alternate starting with the CPU,
    // one access every four cycles.
    task automatic test_round_robin();
        int cyc;
        int n;
        int prev;
        bit last_m;
        bit got;
        bit expv;
        reset0 = 1'b1;
        repeat (2) @(negedge clk);
        reset0 = 1'b0;
        last_m = OWN_VID;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'($urandom_range(0, 1));
        bus0.cpu_addr = 16'h2100 + 16'($urandom_range(0, 3)); bus0.cpu_wdata = 16'($urandom);
        bus0.vid_req = 1'b1; bus0.vid_addr = 16'h2100 + 16'($urandom_range(0, 7));
        cyc = 0; n = 0; prev = -1;
        while (n < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus0.cpu_ack === 1'b1 && bus0.vid_ack === 1'b1) begin
                checks++; errors++;
                $display("FAIL rr_both_ack: cpu_ack and vid_ack both 1 at cycle %0d", cyc);
                n++;
            end else if (bus0.cpu_ack === 1'b1 || bus0.vid_ack === 1'b1) begin
                got  = (bus0.cpu_ack === 1'b1) ? OWN_CPU : OWN_VID;
                expv = (last_m == OWN_CPU) ? OWN_VID : OWN_CPU;
                checks++;
                if (got != expv) begin
                    errors++;
                    $display("FAIL rr_order grant %0d: owner=%0d expected %0d (0=CPU 1=VID)",
                             n, got, expv);
                end
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev != 4) begin
                        errors++;
                        $display("FAIL rr_spacing grant %0d: spacing=%0d expected 4", n, cyc - prev);
                    end
                end
                if (got == OWN_CPU) begin
                    if (bus0.cpu_we) begin
                        model_mem[int'(bus0.cpu_addr)] = bus0.cpu_wdata;
                    end else begin
                        checks++;
                        if (bus0.cpu_rdata !== model_rd(bus0.cpu_addr)) begin
                            errors++;
                            $display("FAIL rr_cpu_rdata: cpu_rdata=%h expected %h",
                                     bus0.cpu_rdata, model_rd(bus0.cpu_addr));
                        end
                    end
                    bus0.cpu_we = 1'($urandom_range(0, 1));
                    bus0.cpu_addr = 16'h2100 + 16'($urandom_range(0, 3));
                    bus0.cpu_wdata = 16'($urandom);
                end else begin
                    checks++;
                    if (bus0.vid_rdata !== model_rd(bus0.vid_addr)) begin
                        errors++;
                        $display("FAIL rr_vid_rdata: vid_rdata=%h expected %h",
                                 bus0.vid_rdata, model_rd(bus0.vid_addr));
                    end
                    bus0.vid_addr = 16'h2100 + 16'($urandom_range(0, 7));
                end
                last_m = got;
                prev = cyc;
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL rr_count: grants=%0d expected 8 within budget", n);
        end
        bus0.cpu_req = 1'b0; bus0.vid_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Priority mode: video starves while the CPU requests, then is served.
    task automatic test_cpu_priority();
        int cyc;
        int ncpu;
        int vid_hits;
        int wait_cyc;
        bit vseen;
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'($urandom);
        bus1.vid_req = 1'b1; bus1.vid_addr = 16'($urandom);
        cyc = 0; ncpu = 0; vid_hits = 0;
        while (ncpu < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus1.vid_ack === 1'b1) vid_hits++;
            if (bus1.cpu_ack === 1'b1) begin
                checks++;
                if (bus1.cpu_rdata !== pat(bus1.cpu_addr)) begin
                    errors++;
                    $display("FAIL prio_cpu_rdata: cpu_rdata=%h expected %h",
                             bus1.cpu_rdata, pat(bus1.cpu_addr));
                end
                ncpu++;
                if (ncpu < 5) bus1.cpu_addr = 16'($urandom);
            end
        end
        bus1.cpu_req = 1'b0;
        checks++;
        if (ncpu != 5 || vid_hits != 0) begin
            errors++;
            $display("FAIL prio_starve: cpu_acks=%0d vid_acks=%0d expected 5 and 0", ncpu, vid_hits);
        end
        vseen = 1'b0; wait_cyc = 0;
        while (!vseen && wait_cyc < 4) begin
            @(negedge clk);
            wait_cyc++;
            if (bus1.vid_ack === 1'b1) vseen = 1'b1;
        end
        checks++;
        if (!vseen) begin
            errors++;
            $display("FAIL prio_vid_after_drop: vid_ack not seen within %0d cycles, expected 4", wait_cyc);
        end
        checks++;
        if (bus1.vid_rdata !== pat(bus1.vid_addr)) begin
            errors++;
            $display("FAIL prio_vid_rdata: vid_rdata=%h expected %h", bus1.vid_rdata, pat(bus1.vid_addr));
        end
        bus1.vid_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Reset lands while a CPU write is in ACCESS.
    task automatic test_reset_mid_access();
        logic [15:0] d;
        cpu_access(1'b0, 16'h2000, 16'h0000, "pre_reset_read");
        d = 16'($urandom);
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h3000; bus0.cpu_wdata = d;
        @(negedge clk);
        checks++;
        if (bus0.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: mem_we=%b expected 1 during ACCESS", bus0.mem_we);
        end
        reset0 = 1'b1; bus0.cpu_req = 1'b0;
        @(negedge clk);
        reset0 = 1'b0;
        checks++;
        if (bus0.mem_we !== 1'b0 || bus0.cpu_rdata !== 16'h0 || bus0.vid_rdata !== 16'h0) begin
            errors++;
            $display("FAIL midreset_clear: mem_we=%b cpu_rdata=%h vid_rdata=%h expected 0 0 0",
                     bus0.mem_we, bus0.cpu_rdata, bus0.vid_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus0.cpu_ack !== 1'b0 || bus0.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_ack cycle %0d: cpu_ack=%b mem_we=%b expected 0 0",
                         i, bus0.cpu_ack, bus0.mem_we);
            end
            @(negedge clk);
        end
        cpu_access(1'b0, 16'h2000, 16'h0000, "post_reset_read");
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_random_cpu();
        test_round_robin();
        test_cpu_priority();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
